// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall/flush sequencer.
// The stages drive requests through master; the sequencer answers through slave.
interface pipe_stall_ctrl_if #(
  parameter int MC_CNT_W = 6
);
  logic                id_stallreq;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_cycles;
  logic                ex_mc_abort;
  logic                flush_req;
  logic [31:0]         flush_pc;

  logic [5:0]          stall;
  logic                bubble_id_ex;
  logic                bubble_ex_mem;
  logic                ex_mc_busy;
  logic                ex_mc_done;
  logic                flush;
  logic [31:0]         new_pc;

  modport master (
    output id_stallreq, ex_mc_start, ex_mc_cycles, ex_mc_abort, flush_req, flush_pc,
    input  stall, bubble_id_ex, bubble_ex_mem, ex_mc_busy, ex_mc_done, flush, new_pc
  );

  modport slave (
    input  id_stallreq, ex_mc_start, ex_mc_cycles, ex_mc_abort, flush_req, flush_pc,
    output stall, bubble_id_ex, bubble_ex_mem, ex_mc_busy, ex_mc_done, flush, new_pc
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges ID/EX stall requests into a hold vector, counts down
// multi-cycle EX ops and issues a registered flush with redirect PC.
module pipe_stall_ctrl #(
  parameter int MC_CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  pipe_io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MC_RUN = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  localparam logic [MC_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [MC_CNT_W-1:0] CNT_ONE  = MC_CNT_W'(1);
  localparam logic [5:0]          STALL_EX = 6'b001111;
  localparam logic [5:0]          STALL_ID = 6'b000111;

  state_e              state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic [31:0]         new_pc_q, new_pc_d;

  logic                ex_stall;
  logic                mc_done;
  logic                id_stall;
  logic [5:0]          stall;
  logic                bubble_id_ex;
  logic                bubble_ex_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  // A flush request overrides everything, including a running multi-cycle op.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    if (pipe_io.flush_req) begin
      state_d  = FLUSH;
      cnt_d    = CNT_ZERO;
      flush_d  = 1'b1;
      new_pc_d = pipe_io.flush_pc;
    end else begin
      case (state_q)
        IDLE: begin
          if (pipe_io.ex_mc_start && (pipe_io.ex_mc_cycles != CNT_ZERO)) begin
            state_d = MC_RUN;
            cnt_d   = pipe_io.ex_mc_cycles;
          end
        end
        MC_RUN: begin
          if (pipe_io.ex_mc_abort || (cnt_q <= CNT_ONE)) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        FLUSH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // EX hold covers the start cycle plus every counted cycle except the last,
  // which instead releases EX with the done pulse. An abort still holds once.
  always_comb begin
    ex_stall = 1'b0;
    mc_done  = 1'b0;
    id_stall = 1'b0;
    if (!rst && !pipe_io.flush_req) begin
      case (state_q)
        IDLE: begin
          if (pipe_io.ex_mc_start) begin
            if (pipe_io.ex_mc_cycles != CNT_ZERO) begin
              ex_stall = 1'b1;
            end else begin
              mc_done = 1'b1;
            end
          end
          id_stall = pipe_io.id_stallreq;
        end
        MC_RUN: begin
          if (pipe_io.ex_mc_abort || (cnt_q > CNT_ONE)) begin
            ex_stall = 1'b1;
          end else begin
            mc_done = 1'b1;
          end
          id_stall = pipe_io.id_stallreq;
        end
        default: begin
          ex_stall = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall         = 6'b000000;
    bubble_id_ex  = 1'b0;
    bubble_ex_mem = 1'b0;
    if (ex_stall) begin
      stall         = STALL_EX;
      bubble_ex_mem = 1'b1;
    end else if (id_stall) begin
      stall        = STALL_ID;
      bubble_id_ex = 1'b1;
    end
  end

  assign pipe_io.stall         = stall;
  assign pipe_io.bubble_id_ex  = bubble_id_ex;
  assign pipe_io.bubble_ex_mem = bubble_ex_mem;
  assign pipe_io.ex_mc_busy    = (state_q == MC_RUN);
  assign pipe_io.ex_mc_done    = mc_done;
  assign pipe_io.flush         = flush_q;
  assign pipe_io.new_pc        = new_pc_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; expected outputs are hand-derived per cycle.
// Observation word: {stall[5:0], bubble_id_ex, bubble_ex_mem, ex_mc_busy, ex_mc_done, flush}.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic        id;
    logic        start;
    logic [5:0]  cyc;
    logic        abort;
    logic        freq;
    logic [31:0] pc;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pipe_stall_ctrl_if #(.MC_CNT_W(6)) pif ();

  pipe_stall_ctrl #(.MC_CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_io (pif)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {pif.stall, pif.bubble_id_ex, pif.bubble_ex_mem, pif.ex_mc_busy,
            pif.ex_mc_done, pif.flush};
  endfunction

  task automatic driveInputs(input stim_t s);
    pif.id_stallreq  = s.id;
    pif.ex_mc_start  = s.start;
    pif.ex_mc_cycles = s.cyc;
    pif.ex_mc_abort  = s.abort;
    pif.flush_req    = s.freq;
    pif.flush_pc     = s.pc;
  endtask

  // Inputs change just after the rising edge; outputs are observed at the falling edge.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    driveInputs(s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t allHigh = {1'b1, 1'b1, 6'd3, 1'b1, 1'b1, 32'h0000_1234};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(allHigh);
      checks++;
      if (outs() !== 11'b0) begin
        failures++;
        $display("[TB] FAIL reset_outs cyc%0d: got %b expected %b", i, outs(), 11'b0);
      end
      checks++;
      if (pif.new_pc !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_new_pc cyc%0d: got %h expected %h", i, pif.new_pc, 32'h0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    driveInputs('0);
    @(negedge clk);
    checks++;
    if (outs() !== 11'b0) begin
      failures++;
      $display("[TB] FAIL idle_outs: got %b expected %b", outs(), 11'b0);
    end
    checks++;
    if (pif.new_pc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL idle_new_pc: got %h expected %h", pif.new_pc, 32'h0);
    end
  endtask

  task automatic test_id_hazard();
    stim_t       st [3];
    logic [10:0] ex [3];
    st[0] = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0}; ex[0] = {6'b000111, 5'b10000};
    st[1] = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0}; ex[1] = {6'b000111, 5'b10000};
    st[2] = '0;                                     ex[2] = 11'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(st[i]);
      checks++;
      if (outs() !== ex[i]) begin
        failures++;
        $display("[TB] FAIL id_hazard cyc%0d: got %b expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_multicycle();
    stim_t       st [5];
    logic [10:0] ex [5];
    st[0] = {1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 32'h0}; ex[0] = {6'b001111, 5'b01000};
    st[1] = {1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 32'h0}; ex[1] = {6'b001111, 5'b01100};
    st[2] = '0;                                     ex[2] = {6'b001111, 5'b01100};
    st[3] = '0;                                     ex[3] = {6'b000000, 5'b00110};
    st[4] = '0;                                     ex[4] = 11'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(st[i]);
      checks++;
      if (outs() !== ex[i]) begin
        failures++;
        $display("[TB] FAIL multicycle cyc%0d: got %b expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_overlap();
    stim_t       st [4];
    logic [10:0] ex [4];
    st[0] = {1'b1, 1'b1, 6'd2, 1'b0, 1'b0, 32'h0}; ex[0] = {6'b001111, 5'b01000};
    st[1] = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0}; ex[1] = {6'b001111, 5'b01100};
    st[2] = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0}; ex[2] = {6'b000111, 5'b10110};
    st[3] = '0;                                     ex[3] = 11'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(st[i]);
      checks++;
      if (outs() !== ex[i]) begin
        failures++;
        $display("[TB] FAIL overlap cyc%0d: got %b expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_flush_mid_op();
    stim_t       st [6];
    logic [10:0] ex [6];
    st[0] = {1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 32'h0};          ex[0] = {6'b001111, 5'b01000};
    st[1] = '0;                                              ex[1] = {6'b001111, 5'b01100};
    st[2] = {1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0000_0180};  ex[2] = {6'b000000, 5'b00100};
    st[3] = '0;                                              ex[3] = {6'b000000, 5'b00001};
    st[4] = '0;                                              ex[4] = 11'b0;
    st[5] = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0};          ex[5] = {6'b000111, 5'b10000};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(st[i]);
      checks++;
      if (outs() !== ex[i]) begin
        failures++;
        $display("[TB] FAIL flush_mid_op cyc%0d: got %b expected %b", i, outs(), ex[i]);
      end
      if (i == 3) begin
        checks++;
        if (pif.new_pc !== 32'h0000_0180) begin
          failures++;
          $display("[TB] FAIL flush_mid_op_pc: got %h expected %h", pif.new_pc, 32'h0000_0180);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t       st [5];
    logic [10:0] ex [5];
    logic [31:0] pc [5];
    st[0] = {1'b1, 1'b1, 6'd4, 1'b0, 1'b1, 32'h0000_0200}; ex[0] = 11'b0;                    pc[0] = 32'h0;
    st[1] = {1'b1, 1'b1, 6'd4, 1'b0, 1'b1, 32'h0000_0300}; ex[1] = {6'b000000, 5'b00001};    pc[1] = 32'h0000_0200;
    st[2] = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0};         ex[2] = {6'b000000, 5'b00001};    pc[2] = 32'h0000_0300;
    st[3] = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0};         ex[3] = {6'b000111, 5'b10000};    pc[3] = 32'h0000_0300;
    st[4] = '0;                                             ex[4] = 11'b0;                    pc[4] = 32'h0000_0300;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(st[i]);
      checks++;
      if (outs() !== ex[i]) begin
        failures++;
        $display("[TB] FAIL back_to_back cyc%0d: got %b expected %b", i, outs(), ex[i]);
      end
      if (i >= 1) begin
        checks++;
        if (pif.new_pc !== pc[i]) begin
          failures++;
          $display("[TB] FAIL back_to_back_pc cyc%0d: got %h expected %h", i, pif.new_pc, pc[i]);
        end
      end
    end
  endtask

  task automatic test_edge_counts();
    stim_t       st [5];
    logic [10:0] ex [5];
    int          stallCycles;
    int          doneAt;
    int          doneCount;

    applyStimulus({1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0});
    checks++;
    if (outs() !== {6'b000000, 5'b00010}) begin
      failures++;
      $display("[TB] FAIL n0_done: got %b expected %b", outs(), {6'b000000, 5'b00010});
    end
    applyStimulus('0);
    checks++;
    if (outs() !== 11'b0) begin
      failures++;
      $display("[TB] FAIL n0_after: got %b expected %b", outs(), 11'b0);
    end

    stallCycles = 0;
    doneAt      = -1;
    doneCount   = 0;
    for (int i = 0; i < 66; i++) begin
      applyStimulus((i == 0) ? stim_t'({1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 32'h0}) : stim_t'('0));
      if (pif.stall === 6'b001111 && pif.bubble_ex_mem === 1'b1) stallCycles++;
      if (pif.ex_mc_done === 1'b1) begin
        doneAt = i;
        doneCount++;
      end
    end
    checks++;
    if (stallCycles !== 63) begin
      failures++;
      $display("[TB] FAIL n63_stall_cycles: got %0d expected %0d", stallCycles, 63);
    end
    checks++;
    if (doneAt !== 63 || doneCount !== 1) begin
      failures++;
      $display("[TB] FAIL n63_done: got cycle %0d count %0d expected cycle 63 count 1", doneAt, doneCount);
    end

    st[0] = {1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 32'h0}; ex[0] = {6'b001111, 5'b01000};
    st[1] = '0;                                     ex[1] = {6'b001111, 5'b01100};
    st[2] = {1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0}; ex[2] = {6'b001111, 5'b01100};
    st[3] = '0;                                     ex[3] = 11'b0;
    st[4] = '0;                                     ex[4] = 11'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(st[i]);
      checks++;
      if (outs() !== ex[i]) begin
        failures++;
        $display("[TB] FAIL abort cyc%0d: got %b expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  initial begin
    driveInputs('0);
    test_reset();
    test_id_hazard();
    test_multicycle();
    test_overlap();
    test_flush_mid_op();
    test_back_to_back();
    test_edge_counts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "[TB] timeout");
  end

endmodule
